// File: rtl/cola_vend_fsm.sv
// rtl/cola_vend_fsm.sv - coin-accumulating single-product vending controller
module cola_vend_fsm #(
  parameter int PRICE = 3,
  parameter int CW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pi_money,
  output logic po_cola
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [CW-1:0] PRICE_W  = CW'(PRICE);
  localparam logic [CW-1:0] PRICE_M1 = CW'(PRICE - 1);

  state_t        state;
  logic [CW-1:0] credit;
  logic          credit_bad;

  // State and credit must agree (IDLE <=> zero) and credit must stay below PRICE;
  // anything else is treated as corruption and dropped back to IDLE.
  assign credit_bad = (credit >= PRICE_W) || ((state == IDLE) != (credit == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      credit  <= '0;
      po_cola <= 1'b0;
    end else begin
      po_cola <= 1'b0;
      if (credit_bad) begin
        state  <= IDLE;
        credit <= '0;
      end else if (pi_money) begin
        if (credit == PRICE_M1) begin
          state   <= IDLE;
          credit  <= '0;
          po_cola <= 1'b1;
        end else begin
          state  <= ACCUM;
          credit <= credit + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cola_vend_fsm.sv
// tb/tb_cola_vend_fsm.sv - scoreboard bench for cola_vend_fsm with PRICE=3
module tb_cola_vend_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pi_money = 1'b0;
  logic po_cola;

  int n_assert = 0;
  int n_fail = 0;
  int pulses = 0;
  int coins = 0;
  int m_credit = 0;
  logic prev_po = 1'b0;
  logic exp_q[$];

  cola_vend_fsm #(.PRICE(3), .CW(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pi_money(pi_money),
    .po_cola(po_cola)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: one expected po_cola value per sampled edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_credit = 0;
      exp_q.delete();
    end else begin
      if (pi_money) begin
        coins++;
        if (m_credit == 2) begin
          m_credit = 0;
          exp_q.push_back(1'b1);
        end else begin
          m_credit++;
          exp_q.push_back(1'b0);
        end
      end else begin
        exp_q.push_back(1'b0);
      end
    end
  end

  always @(negedge clk) begin
    logic exp_po;
    exp_po = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    check("po_cola", int'(po_cola), int'(exp_po));
    if (prev_po && po_cola)
      check("no_back_to_back", 1, 0);
    if (po_cola === 1'b1) pulses++;
    prev_po = po_cola;
  end

  task automatic coin(input logic v);
    @(negedge clk);
    pi_money = v;
  endtask

  task automatic idle(input int n);
    repeat (n) coin(1'b0);
  endtask

  initial begin
    int p0;
    int c0;

    repeat (10) begin
      @(negedge clk);
      pi_money = ~pi_money;
    end
    check("reset_credit", int'(dut.credit), 0);
    check("reset_pulses", pulses, 0);
    @(negedge clk);
    pi_money = 1'b0;
    rst_n = 1'b1;

    p0 = pulses;
    repeat (3) coin(1'b1);
    idle(3);
    check("three_coins_pulses", pulses - p0, 1);
    check("three_coins_credit", int'(dut.credit), 0);

    p0 = pulses;
    coin(1'b1); coin(1'b0); coin(1'b0); coin(1'b1); coin(1'b0); coin(1'b1);
    idle(3);
    check("gapped_coins_pulses", pulses - p0, 1);

    p0 = pulses;
    repeat (9) coin(1'b1);
    idle(3);
    check("held_high_pulses", pulses - p0, 3);

    p0 = pulses;
    coin(1'b1); coin(1'b1); coin(1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("mid_reset_credit", int'(dut.credit), 0);
    coin(1'b1);
    idle(3);
    check("after_reset_one_coin", pulses - p0, 0);
    coin(1'b1); coin(1'b1);
    idle(3);
    check("after_reset_three_coins", pulses - p0, 1);

    p0 = pulses;
    c0 = coins;
    repeat (1200) coin(1'($urandom_range(0, 1)));
    idle(3);
    check("random_pulse_count", pulses - p0, (coins - c0) / 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
